// File: rtl/mem_arb.sv
// Two-port arbiter sharing one single-port synchronous RAM between port 0 (CPU)
// and port 1 (DMA/debug): round-robin or fixed priority, starvation guard, bus lock.
module mem_arb #(
  parameter int AW       = 9,
  parameter int DW       = 32,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          valid0,
  output logic          valid1,
  output logic [DW-1:0] rdata,
  output logic          m_cs,
  output logic          m_wr,
  output logic [AW-1:0] m_a,
  output logic [DW-1:0] m_i,
  input  logic [DW-1:0] m_o,
  output logic [1:0]    dbg_owner,
  output logic          dbg_ptr,
  output logic [7:0]    dbg_w0,
  output logic [7:0]    dbg_w1
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam logic [7:0] WMAX = 8'(MAX_WAIT);

  owner_t     owner;
  logic       ptr;      // last granted port (1 = port 1)
  logic [7:0] w0;
  logic [7:0] w1;
  logic       sat0;
  logic       sat1;
  logic       pick1;
  logic       sel0;
  logic       sel1;

  // Handshake: a port raises reqN and holds wrN/lockN/aN/dN stable until it
  // sees gntN high in a cycle; that cycle is the access. gnt is combinational.
  always_comb begin
    sat0  = (w0 >= WMAX);
    sat1  = (w1 >= WMAX);
    pick1 = 1'b0;
    if (sat0 && sat1)  pick1 = ~ptr;
    else if (sat0)     pick1 = 1'b0;
    else if (sat1)     pick1 = 1'b1;
    else if (MODE == 0) pick1 = ~ptr;
    else               pick1 = 1'b0;

    sel0 = 1'b0;
    sel1 = 1'b0;
    case (owner)
      OWN_P0: sel0 = req0;
      OWN_P1: sel1 = req1;
      default: begin
        if (req0 && req1) begin
          sel0 = ~pick1;
          sel1 = pick1;
        end else begin
          sel0 = req0;
          sel1 = req1;
        end
      end
    endcase
  end

  // Reset blocks grants immediately, not just at the next edge.
  assign gnt0 = resetn & sel0;
  assign gnt1 = resetn & sel1;

  always_comb begin
    m_cs = gnt0 | gnt1;
    m_wr = 1'b0;
    if (gnt0)      m_wr = wr0;
    else if (gnt1) m_wr = wr1;
    m_a = gnt1 ? a1 : a0;
    m_i = gnt1 ? d1 : d0;
  end

  assign rdata = m_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner  <= OWN_NONE;
      ptr    <= 1'b1;
      w0     <= 8'd0;
      w1     <= 8'd0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end else begin
      if (gnt0) begin
        owner <= lock0 ? OWN_P0 : OWN_NONE;
        ptr   <= 1'b0;
      end else if (gnt1) begin
        owner <= lock1 ? OWN_P1 : OWN_NONE;
        ptr   <= 1'b1;
      end

      if (req0 && !gnt0) w0 <= sat0 ? WMAX : w0 + 8'd1;
      else               w0 <= 8'd0;
      if (req1 && !gnt1) w1 <= sat1 ? WMAX : w1 + 8'd1;
      else               w1 <= 8'd0;

      valid0 <= gnt0 & ~wr0;
      valid1 <= gnt1 & ~wr1;
    end
  end

  assign dbg_owner = owner;
  assign dbg_ptr   = ptr;
  assign dbg_w0    = w0;
  assign dbg_w1    = w1;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a round-robin instance (a) and a fixed-priority instance
// with MAX_WAIT=3 (b) share stimulus; each has its own write-first RAM model.
module tb_mem_arb;
  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct {
    logic          rst, r0, r1, w0, w1, l0, l1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [DW-1:0] x0, x1;   // expected read data if that port's read is granted
    logic [1:0]    ga, gb;   // expected {gnt1, gnt0} for instance a / b
    logic          chk;
    logic [7:0]    aw0, aw1, bw0, bw1;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic          gnt0_a, gnt1_a, va0_a, va1_a, cs_a, wr_a, ptr_a;
  logic          gnt0_b, gnt1_b, va0_b, va1_b, cs_b, wr_b, ptr_b;
  logic [DW-1:0] rd_a, rd_b, mi_a, mi_b, mo_a, mo_b;
  logic [AW-1:0] ma_a, ma_b;
  logic [1:0]    own_a, own_b;
  logic [7:0]    w0_a, w1_a, w0_b, w1_b;

  logic [DW-1:0] mem_a [512];
  logic [DW-1:0] mem_b [512];

  logic [DW:0]   exp_qa[$];
  logic [DW:0]   exp_qb[$];
  vec_t          vecs[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW), .MODE(0), .MAX_WAIT(15)) dut_a (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .lock0(lock0), .lock1(lock1), .a0(a0), .a1(a1), .d0(d0), .d1(d1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .valid0(va0_a), .valid1(va1_a), .rdata(rd_a),
    .m_cs(cs_a), .m_wr(wr_a), .m_a(ma_a), .m_i(mi_a), .m_o(mo_a),
    .dbg_owner(own_a), .dbg_ptr(ptr_a), .dbg_w0(w0_a), .dbg_w1(w1_a));

  mem_arb #(.AW(AW), .DW(DW), .MODE(1), .MAX_WAIT(3)) dut_b (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .lock0(lock0), .lock1(lock1), .a0(a0), .a1(a1), .d0(d0), .d1(d1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .valid0(va0_b), .valid1(va1_b), .rdata(rd_b),
    .m_cs(cs_b), .m_wr(wr_b), .m_a(ma_b), .m_i(mi_b), .m_o(mo_b),
    .dbg_owner(own_b), .dbg_ptr(ptr_b), .dbg_w0(w0_b), .dbg_w1(w1_b));

  // Write-first synchronous RAMs, one per instance.
  always @(posedge clk) begin
    if (cs_a) begin
      if (wr_a) begin mem_a[ma_a] <= mi_a; mo_a <= mi_a; end
      else mo_a <= mem_a[ma_a];
    end
    if (cs_b) begin
      if (wr_b) begin mem_b[ma_b] <= mi_b; mo_b <= mi_b; end
      else mo_b <= mem_b[ma_b];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    v.a0 = AW'($urandom_range(0, 511));
    v.a1 = AW'($urandom_range(0, 511));
    v.d0 = $urandom;
    v.d1 = $urandom;
    return v;
  endfunction

  function automatic vec_t p0(vec_t vi, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
    vec_t v = vi;
    v.r0 = 1'b1; v.w0 = w; v.l0 = l; v.a0 = a;
    if (w) v.d0 = d; else v.x0 = d;
    return v;
  endfunction

  function automatic vec_t p1(vec_t vi, logic w, logic l, logic [AW-1:0] a, logic [DW-1:0] d);
    vec_t v = vi;
    v.r1 = 1'b1; v.w1 = w; v.l1 = l; v.a1 = a;
    if (w) v.d1 = d; else v.x1 = d;
    return v;
  endfunction

  function automatic vec_t g(vec_t vi, logic [1:0] ga, logic [1:0] gb);
    vec_t v = vi;
    v.ga = ga; v.gb = gb;
    return v;
  endfunction

  function automatic vec_t rs(vec_t vi);
    vec_t v = vi;
    v.rst = 1'b1; v.ga = 2'b00; v.gb = 2'b00;
    return v;
  endfunction

  function automatic vec_t cw(vec_t vi, logic [7:0] aw0, logic [7:0] aw1,
                              logic [7:0] bw0, logic [7:0] bw1);
    vec_t v = vi;
    v.chk = 1'b1; v.aw0 = aw0; v.aw1 = aw1; v.bw0 = bw0; v.bw1 = bw1;
    return v;
  endfunction

  task automatic sb_check(input int inst, input string nm, input logic v0, input logic v1,
                          input logic [DW-1:0] rd);
    logic [DW:0] e;
    bit          have;
    int          sz;
    have = 0;
    e    = '0;
    sz   = (inst == 0) ? exp_qa.size() : exp_qb.size();
    if (sz > 0) begin
      have = 1;
      if (inst == 0) e = exp_qa.pop_front();
      else           e = exp_qb.pop_front();
    end
    if (v0 || v1) begin
      n_cmp++;
      if (!have) begin
        n_err++;
        $display("FAIL %s unexpected valid: got valid1/0=%b%b, want none", nm, v1, v0);
      end else if ({v1, v0} !== (e[DW] ? 2'b10 : 2'b01) || rd !== e[DW-1:0]) begin
        n_err++;
        $display("FAIL %s read return: got valid1/0=%b%b rdata=%h, want port%0d rdata=%h",
                 nm, v1, v0, rd, e[DW], e[DW-1:0]);
      end
    end else if (have) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s missing valid: got none, want port%0d rdata=%h", nm, e[DW], e[DW-1:0]);
    end
  endtask

  task automatic check_inst(input int inst, input string nm, input vec_t v, input logic [1:0] eg,
                            input logic [1:0] gg, input logic cs, input logic wr,
                            input logic [AW-1:0] ma, input logic [DW-1:0] mi,
                            input logic [7:0] gw0, input logic [7:0] gw1,
                            input logic [7:0] ew0, input logic [7:0] ew1);
    logic ewr;
    ewr = eg[0] ? v.w0 : (eg[1] ? v.w1 : 1'b0);
    chk({nm, " gnt"}, 32'(gg), 32'(eg));
    chk({nm, " m_cs"}, 32'(cs), 32'(|eg));
    chk({nm, " m_wr"}, 32'(wr), 32'(ewr));
    chk({nm, " m_a"}, 32'(ma), 32'(eg[1] ? v.a1 : v.a0));
    chk({nm, " m_i"}, mi, eg[1] ? v.d1 : v.d0);
    if (v.chk) begin
      chk({nm, " w0"}, 32'(gw0), 32'(ew0));
      chk({nm, " w1"}, 32'(gw1), 32'(ew1));
    end
    if (eg[0] && !v.w0) begin
      if (inst == 0) exp_qa.push_back({1'b0, v.x0});
      else           exp_qb.push_back({1'b0, v.x0});
    end
    if (eg[1] && !v.w1) begin
      if (inst == 0) exp_qa.push_back({1'b1, v.x1});
      else           exp_qb.push_back({1'b1, v.x1});
    end
  endtask

  initial begin
    vec_t c;
    // preload and single-port write/read
    vecs.push_back(cw(rs(idle()), 0, 0, 0, 0));
    vecs.push_back(g(p0(idle(), 1, 0, 9'h010, 32'hA5A5_0001), 2'b01, 2'b01));
    vecs.push_back(g(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 2'b01, 2'b01));
    vecs.push_back(g(p0(idle(), 1, 0, 9'h100, 32'h1111_0000), 2'b01, 2'b01));
    vecs.push_back(g(p0(idle(), 1, 0, 9'h101, 32'h2222_0001), 2'b01, 2'b01));
    vecs.push_back(g(p1(idle(), 1, 0, 9'h020, 32'hCAFE_0020), 2'b10, 2'b10));
    vecs.push_back(rs(idle()));
    // contention: a alternates from P0, b starves P1 for MAX_WAIT cycles
    for (int k = 0; k < 8; k++) begin
      c = p1(p0(idle(), 0, 0, 9'h100, 32'h1111_0000), 0, 0, 9'h101, 32'h2222_0001);
      c = g(c, (k % 2 == 0) ? 2'b01 : 2'b10, (k % 4 == 3) ? 2'b10 : 2'b01);
      if (k == 3) c = cw(c, 0, 1, 0, 3);
      if (k == 4) c = cw(c, 1, 0, 1, 0);
      vecs.push_back(c);
    end
    vecs.push_back(g(idle(), 2'b00, 2'b00));
    vecs.push_back(rs(idle()));
    // lock: P1 locked read, drops req, then unlocked write; P0 waits throughout
    vecs.push_back(g(p1(idle(), 0, 1, 9'h020, 32'hCAFE_0020), 2'b10, 2'b10));
    vecs.push_back(cw(g(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 2'b00, 2'b00), 0, 0, 0, 0));
    vecs.push_back(g(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 2'b00, 2'b00));
    vecs.push_back(g(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 2'b00, 2'b00));
    vecs.push_back(cw(g(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 2'b00, 2'b00), 3, 0, 3, 0));
    vecs.push_back(cw(g(p1(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 1, 0, 9'h020, 32'hBEEF_0020),
                        2'b10, 2'b10), 4, 0, 3, 0));
    vecs.push_back(cw(g(p0(idle(), 0, 0, 9'h020, 32'hBEEF_0020), 2'b01, 2'b01), 5, 0, 3, 0));
    vecs.push_back(cw(g(idle(), 2'b00, 2'b00), 0, 0, 0, 0));
    // write then read of the top word from the other port
    vecs.push_back(g(p0(idle(), 1, 0, 9'h1FF, 32'h1234_5678), 2'b01, 2'b01));
    vecs.push_back(g(p1(idle(), 0, 0, 9'h1FF, 32'h1234_5678), 2'b10, 2'b10));
    vecs.push_back(g(idle(), 2'b00, 2'b00));
    // reset in the cycle after a P1 read grant
    vecs.push_back(g(p1(idle(), 0, 0, 9'h020, 32'hBEEF_0020), 2'b10, 2'b10));
    vecs.push_back(cw(rs(p1(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 0, 0, 9'h020, 32'hBEEF_0020)),
                      0, 0, 0, 0));
    vecs.push_back(cw(g(p1(p0(idle(), 0, 0, 9'h010, 32'hA5A5_0001), 0, 0, 9'h020, 32'hBEEF_0020),
                        2'b01, 2'b01), 0, 0, 0, 0));
    vecs.push_back(g(idle(), 2'b00, 2'b00));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      resetn = ~v.rst;
      req0 = v.r0; req1 = v.r1; wr0 = v.w0; wr1 = v.w1; lock0 = v.l0; lock1 = v.l1;
      a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1;
      @(negedge clk);
      if (v.rst) begin
        chk($sformatf("v%0d a valid in reset", i), 32'({va1_a, va0_a}), 32'd0);
        chk($sformatf("v%0d b valid in reset", i), 32'({va1_b, va0_b}), 32'd0);
        exp_qa.delete();
        exp_qb.delete();
      end else begin
        sb_check(0, $sformatf("v%0d a", i), va0_a, va1_a, rd_a);
        sb_check(1, $sformatf("v%0d b", i), va0_b, va1_b, rd_b);
      end
      check_inst(0, $sformatf("v%0d a", i), v, v.ga, {gnt1_a, gnt0_a}, cs_a, wr_a, ma_a, mi_a,
                 w0_a, w1_a, v.aw0, v.aw1);
      check_inst(1, $sformatf("v%0d b", i), v, v.gb, {gnt1_b, gnt0_b}, cs_b, wr_b, ma_b, mi_b,
                 w0_b, w1_b, v.bw0, v.bw1);
      @(posedge clk);
      #1;
    end

    // reset asserted in the middle of a granted read cycle
    req0 = 1'b1; wr0 = 1'b0; lock0 = 1'b1; a0 = 9'h010;
    req1 = 1'b0; wr1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    chk("midcycle gnt0 before reset", 32'(gnt0_a), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("midcycle a gnt0 in reset", 32'(gnt0_a), 32'd0);
    chk("midcycle b gnt0 in reset", 32'(gnt0_b), 32'd0);
    chk("midcycle a m_cs in reset", 32'(cs_a), 32'd0);
    chk("midcycle b m_cs in reset", 32'(cs_b), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    req0 = 1'b0; lock0 = 1'b0;
    @(negedge clk);
    chk("after reset a valid0", 32'(va0_a), 32'd0);
    chk("after reset b valid0", 32'(va0_b), 32'd0);
    chk("after reset a owner", 32'(own_a), 32'd0);
    chk("after reset a ptr", 32'(ptr_a), 32'd1);
    chk("after reset b ptr", 32'(ptr_b), 32'd1);
    chk("after reset b owner", 32'(own_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares the single-port 512x32 synchronous block RAM (one-cycle read latency, enable/write-enable interface) between the CPU fetch/data port (port 0) and a secondary master (port 1: DMA or debug monitor). It grants at most one access per clock, steers address/data/write-enable to the RAM and routes returned read data to the port that issued the read. It supports round-robin or fixed-priority arbitration with a starvation guard, plus a bus lock for read-modify-write sequences.

## Interface

- AW, 9, RAM word-address width
- DW, 32, data width
- MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 wins) with starvation guard
- MAX_WAIT, 15, cycles a requester may wait before it is forced to top priority (1..255)

- CLK  in  1  clock; all state updates on the rising edge
- RESETN  in  1  reset, asynchronous, active-low
- REQ0 / REQ1  in  1  access request; held until GNTx
- WR0 / WR1  in  1  1 = write, 0 = read; qualified by REQx
- LOCK0 / LOCK1  in  1  keep ownership after this access
- A0 / A1  in  AW  word address
- D0 / D1  in  DW  write data
- GNT0 / GNT1  out  1  access accepted this cycle (combinational)
- VALID0 / VALID1  out  1  RDATA valid for this port (registered)
- RDATA  out  DW  read data, shared; equals M_O
- M_CS  out  1  RAM enable
- M_WR  out  1  RAM write enable
- M_A  out  AW  RAM address
- M_I  out  DW  RAM write data
- M_O  in  DW  RAM read data

## Operation

- Grant is decided combinationally from REQx, LOCKx and registered state: owner (NONE/P0/P1), last-grant pointer, and wait counters W0/W1.
- Decision order:
  1. If owner is P0 or P1, only that port can be granted. The other port stalls regardless of its wait count.
  2. If exactly one REQ is high, that port is granted.
  3. If both are high and one counter has reached MAX_WAIT, that port is granted. If both have reached it, the port not granted last wins.
  4. Otherwise MODE 0 grants the port not granted last, and MODE 1 grants port 0.
- Granted port x: M_CS=1, M_WR=WRx, M_A=Ax, M_I=Dx, GNTx=1. With no grant, M_CS=0, M_WR=0, and M_A/M_I hold port 0 values.
- Owner update on a granted access: it becomes Px if LOCKx=1, and NONE if LOCKx=0. If an owner drops REQ, ownership is kept; the lock is released only by an unlocked granted access.
- Pointer is set to the granted port on every grant.
- Wait counter Wx:
  - Increments, saturating at MAX_WAIT, while REQx=1 and GNTx=0.
  - Clears on GNTx or when REQx=0.
  - Width is 8 bits.
- VALIDx is registered as GNTx & ~WRx, so it is high in the cycle after a granted read. RDATA is M_O unregistered, and the RAM is write-first.
- Back-to-back grants to either port are allowed every cycle. A read grant in cycle n and any grant in n+1 do not conflict.
- Reset (RESETN low) acts immediately:
  - Forces GNTx=0, M_CS=0, M_WR=0, VALIDx=0, owner=NONE, pointer=port 1 (so port 0 wins the first contention in MODE 0), W0=W1=0.
  - An access in flight when reset asserts is dropped, and no VALID is produced.

## Timing

- Request-to-grant takes 0 cycles when uncontended. A requester waits at most MAX_WAIT+1 cycles unless the other port holds a lock.
- Read latency: GNTx in cycle n produces VALIDx and RDATA in cycle n+1. A write completes at the edge that ends the grant cycle.
- Ports must change A/D/WR/LOCK only after the cycle in which GNT was seen.
- Reset deassertion is synchronous to CLK in the system. The first grant is possible in the first cycle RESETN is high.

## Test plan

- Single port 0 write then read: write 0xA5A5_0001 to 0x010 with REQ0 and WR0=1 (GNT0 the same cycle), then read 0x010 -> VALID0=1 one cycle after grant, RDATA=0xA5A5_0001, VALID1 stays 0.
- MODE 0 contention: both ports request reads for 8 cycles -> grants alternate P0,P1,P0,...; the first is P0 after reset; each VALID lands on the matching port.
- MODE 1 starvation, MAX_WAIT=3: REQ0 continuous, REQ1 from cycle 0 -> P0 is granted in cycles 0-2, P1 in cycle 3, then P0 resumes.
- Lock: port 1 does a locked read of 0x020 then an unlocked write of 0x020, while REQ0 is held throughout -> GNT0 stays 0 until the cycle after the unlocked P1 write, W0 saturates, and then P0 is granted.
- Reset mid-read: assert RESETN low in the cycle after GNT1 for a read -> VALID1=0 immediately; after release, owner=NONE, counters=0, and the first contention grants P0.
- Write-first collision: P0 writes 0x1234_5678 to 0x1FF, then P1 reads 0x1FF on the next cycle -> VALID1 with RDATA=0x1234_5678. Address wrap: A0 upper bits beyond AW are not driven onto M_A.
